// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use stall and flush controls for a
// 5-stage pipeline with an 8-entry register file. Hazard outputs are purely
// combinational. Define HAZARD_STATS_EN to build saturating stall/flush/forward
// event counters; otherwise the counter ports are tied to zero and no flops exist.
module hazard_unit #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        reg_read_adr1_d,
  input  logic [2:0]        reg_read_adr2_d,
  input  logic [2:0]        reg_read_adr1_e,
  input  logic [2:0]        reg_read_adr2_e,
  input  logic [2:0]        reg_write_adr_e,
  input  logic              mem_to_reg_e,
  input  logic              reg_write_m,
  input  logic [2:0]        reg_write_adr_m,
  input  logic              reg_write_w,
  input  logic [2:0]        reg_write_adr_w,
  input  logic              PC_source,
  input  logic              stats_clear,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        forward1_e,
  output logic [1:0]        forward2_e,
  output logic [STAT_W-1:0] stall_count,
  output logic [STAT_W-1:0] flush_count,
  output logic [STAT_W-1:0] fwd_count
);

  logic lw_stall;

  // Operand forwarding: Memory result wins over Writeback; register 0 is not special.
  always_comb begin
    forward1_e = 2'b00;
    forward2_e = 2'b00;
    if (reg_write_m && (reg_write_adr_m == reg_read_adr1_e))
      forward1_e = 2'b10;
    else if (reg_write_w && (reg_write_adr_w == reg_read_adr1_e))
      forward1_e = 2'b01;
    if (reg_write_m && (reg_write_adr_m == reg_read_adr2_e))
      forward2_e = 2'b10;
    else if (reg_write_w && (reg_write_adr_w == reg_read_adr2_e))
      forward2_e = 2'b01;
  end

  // Load-use stall plus flushes; a taken branch clears F/D even while stalled.
  always_comb begin
    lw_stall = mem_to_reg_e &&
               ((reg_write_adr_e == reg_read_adr1_d) ||
                (reg_write_adr_e == reg_read_adr2_d));
    stall_f  = lw_stall;
    stall_d  = lw_stall;
    flush_d  = PC_source;
    flush_e  = lw_stall || PC_source;
  end

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] CNT_MAX = '1;

  logic any_fwd;
  assign any_fwd = (forward1_e != 2'b00) || (forward2_e != 2'b00);

  // Saturating event counters; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
      fwd_count   <= '0;
    end else if (stats_clear) begin
      stall_count <= '0;
      flush_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (lw_stall && (stall_count != CNT_MAX))
        stall_count <= stall_count + 1'b1;
      if (PC_source && (flush_count != CNT_MAX))
        flush_count <= flush_count + 1'b1;
      if (any_fwd && (fwd_count != CNT_MAX))
        fwd_count <= fwd_count + 1'b1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = &{1'b0, clk, rst, stats_clear};
  assign stall_count  = '0;
  assign flush_count  = '0;
  assign fwd_count    = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed cases plus randomized stimulus checked against a
// behavioural model of the hazard rules and the event counters.
module tb_hazard_unit;
  localparam int STAT_W = 16;
  localparam int CMAX   = (1 << STAT_W) - 1;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [2:0] reg_read_adr1_d, reg_read_adr2_d, reg_read_adr1_e, reg_read_adr2_e;
  logic [2:0] reg_write_adr_e, reg_write_adr_m, reg_write_adr_w;
  logic mem_to_reg_e, reg_write_m, reg_write_w, PC_source, stats_clear;
  logic stall_f, stall_d, flush_d, flush_e;
  logic [1:0] forward1_e, forward2_e;
  logic [STAT_W-1:0] stall_count, flush_count, fwd_count;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0, exp_flush = 0, exp_fwd = 0;

  always #5 clk = ~clk;

  hazard_unit #(.STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .reg_read_adr1_d(reg_read_adr1_d), .reg_read_adr2_d(reg_read_adr2_d),
    .reg_read_adr1_e(reg_read_adr1_e), .reg_read_adr2_e(reg_read_adr2_e),
    .reg_write_adr_e(reg_write_adr_e), .mem_to_reg_e(mem_to_reg_e),
    .reg_write_m(reg_write_m), .reg_write_adr_m(reg_write_adr_m),
    .reg_write_w(reg_write_w), .reg_write_adr_w(reg_write_adr_w),
    .PC_source(PC_source), .stats_clear(stats_clear),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .forward1_e(forward1_e), .forward2_e(forward2_e),
    .stall_count(stall_count), .flush_count(flush_count), .fwd_count(fwd_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Which stage supplies an Execute operand read from register src.
  function automatic int ref_fwd(input int src);
    if (reg_write_m && int'(reg_write_adr_m) == src) return 2;
    if (reg_write_w && int'(reg_write_adr_w) == src) return 1;
    return 0;
  endfunction

  function automatic bit ref_lw();
    return mem_to_reg_e && (reg_write_adr_e == reg_read_adr1_d || reg_write_adr_e == reg_read_adr2_d);
  endfunction

  task automatic check_comb();
    bit lw;
    lw = ref_lw();
    chk("forward1_e", 32'(forward1_e), 32'(ref_fwd(int'(reg_read_adr1_e))));
    chk("forward2_e", 32'(forward2_e), 32'(ref_fwd(int'(reg_read_adr2_e))));
    chk("stall_f", 32'(stall_f), 32'(lw));
    chk("stall_d", 32'(stall_d), 32'(lw));
    chk("flush_d", 32'(flush_d), 32'(PC_source));
    chk("flush_e", 32'(flush_e), 32'(lw | PC_source));
  endtask

  task automatic check_counts();
    chk("stall_count", 32'(stall_count), STATS ? 32'(exp_stall) : 32'd0);
    chk("flush_count", 32'(flush_count), STATS ? 32'(exp_flush) : 32'd0);
    chk("fwd_count",   32'(fwd_count),   STATS ? 32'(exp_fwd)   : 32'd0);
  endtask

  // Counter model evaluated with the inputs present at the rising edge.
  task automatic model_edge();
    if (rst || stats_clear) begin
      exp_stall = 0; exp_flush = 0; exp_fwd = 0;
    end else begin
      if (ref_lw() && exp_stall < CMAX) exp_stall++;
      if (PC_source && exp_flush < CMAX) exp_flush++;
      if ((ref_fwd(int'(reg_read_adr1_e)) != 0 || ref_fwd(int'(reg_read_adr2_e)) != 0) && exp_fwd < CMAX)
        exp_fwd++;
    end
  endtask

  task automatic cycle();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    #1 check_counts();
  endtask

  task automatic zero_inputs();
    reg_read_adr1_d = 0; reg_read_adr2_d = 0; reg_read_adr1_e = 0; reg_read_adr2_e = 0;
    reg_write_adr_e = 0; reg_write_adr_m = 0; reg_write_adr_w = 0;
    mem_to_reg_e = 0; reg_write_m = 0; reg_write_w = 0; PC_source = 0; stats_clear = 0;
  endtask

  task automatic randomize_inputs();
    reg_read_adr1_d = 3'($urandom); reg_read_adr2_d = 3'($urandom);
    reg_read_adr1_e = 3'($urandom); reg_read_adr2_e = 3'($urandom);
    reg_write_adr_e = 3'($urandom); reg_write_adr_m = 3'($urandom);
    reg_write_adr_w = 3'($urandom);
    mem_to_reg_e = 1'($urandom_range(0, 1));
    reg_write_m  = 1'($urandom_range(0, 1));
    reg_write_w  = 1'($urandom_range(0, 1));
    PC_source    = ($urandom_range(0, 3) == 0);
    stats_clear  = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    #1;
    chk("rst_fwd1", 32'(forward1_e), 32'd0);
    chk("rst_fwd2", 32'(forward2_e), 32'd0);
    chk("rst_flush_e", 32'(flush_e), 32'd0);
    chk("rst_stall_f", 32'(stall_f), 32'd0);
    check_counts();
    cycle();
    rst = 1'b0;
    cycle();

    // Forwarding priority directed cases.
    reg_write_m = 1; reg_write_adr_m = 3; reg_read_adr1_e = 3;
    #1 chk("fwd1_mem", 32'(forward1_e), 32'd2);
    cycle();
    reg_read_adr1_e = 2; reg_write_w = 1; reg_write_adr_w = 2;
    #1 chk("fwd1_wb", 32'(forward1_e), 32'd1);
    cycle();
    reg_write_adr_m = 2;
    #1 chk("fwd1_mem_prio", 32'(forward1_e), 32'd2);
    cycle();
    zero_inputs();
    reg_read_adr2_e = 4; reg_read_adr1_e = 1; reg_write_w = 1; reg_write_adr_w = 4;
    #1 chk("fwd2_wb", 32'(forward2_e), 32'd1);
    chk("fwd1_none", 32'(forward1_e), 32'd0);
    cycle();

    // Branch flush and load-use stall.
    zero_inputs(); reg_read_adr1_d = 1; reg_read_adr2_d = 1; PC_source = 1;
    #1 chk("br_flush_d", 32'(flush_d), 32'd1);
    chk("br_flush_e", 32'(flush_e), 32'd1);
    chk("br_stall_f", 32'(stall_f), 32'd0);
    cycle();
    zero_inputs(); reg_read_adr2_d = 1; reg_write_adr_e = 5; reg_read_adr1_d = 5; mem_to_reg_e = 1;
    #1 chk("lw_stall_d", 32'(stall_d), 32'd1);
    chk("lw_flush_e", 32'(flush_e), 32'd1);
    chk("lw_flush_d", 32'(flush_d), 32'd0);
    cycle();
    mem_to_reg_e = 0;
    #1 chk("nolw_stall_f", 32'(stall_f), 32'd0);
    cycle();
    reg_read_adr1_d = 0; reg_read_adr2_d = 5; mem_to_reg_e = 1; PC_source = 1;
    #1 chk("lw2_stall_f", 32'(stall_f), 32'd1);
    chk("lw2_br_flush_d", 32'(flush_d), 32'd1);
    cycle();

    // Three stall cycles from a cleared counter.
    zero_inputs(); stats_clear = 1; cycle();
    stats_clear = 0; reg_read_adr1_d = 6; reg_read_adr2_d = 6; reg_write_adr_e = 6; mem_to_reg_e = 1;
    repeat (3) cycle();
    chk("stall3", 32'(stall_count), STATS ? 32'd3 : 32'd0);
    stats_clear = 1; cycle();
    chk("stall_cleared", 32'(stall_count), 32'd0);
    stats_clear = 0; repeat (2) cycle();

    // Asynchronous reset mid-count.
    #2 rst = 1'b1;
    exp_stall = 0; exp_flush = 0; exp_fwd = 0;
    #1 chk("async_rst_stall", 32'(stall_count), 32'd0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("resume_stall", 32'(stall_count), STATS ? 32'd1 : 32'd0);

    // Saturation: all three events held beyond full scale.
    stats_clear = 1; cycle(); stats_clear = 0;
    PC_source = 1; reg_write_m = 1; reg_write_adr_m = 0; reg_read_adr1_e = 0;
    repeat (CMAX + 5) begin
      @(posedge clk);
      model_edge();
    end
    #1 check_counts();
    chk("sat_stall", 32'(stall_count), STATS ? 32'(CMAX) : 32'd0);
    chk("sat_fwd", 32'(fwd_count), STATS ? 32'(CMAX) : 32'd0);
    cycle();
    chk("sat_flush_hold", 32'(flush_count), STATS ? 32'(CMAX) : 32'd0);

    // Randomized traffic.
    stats_clear = 1; cycle();
    repeat (1500) begin
      randomize_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard detection and forwarding control for the 5-stage (F/D/E/M/W) pipeline with an 8-entry, 3-bit-addressed register file. Combinationally generates forwarding selects for the two Execute-stage ALU operands, the load-use stall, and the branch/stall flush controls. Sits beside the datapath and drives the F/D and D/E pipeline-register enables and clears plus the E-stage operand muxes. An optional clocked statistics block counts stall, flush and forward events.

## Interface
- STAT_W, 16, width of each statistics counter
- clk  in  1  pipeline clock, rising edge; used by statistics only
- rst  in  1  asynchronous, active-high reset
- reg_read_adr1_d  in  3  source register 1 of instruction in Decode
- reg_read_adr2_d  in  3  source register 2 of instruction in Decode
- reg_read_adr1_e  in  3  source register 1 of instruction in Execute
- reg_read_adr2_e  in  3  source register 2 of instruction in Execute
- reg_write_adr_e  in  3  destination register of instruction in Execute
- mem_to_reg_e  in  1  instruction in Execute is a load
- reg_write_m  in  1  instruction in Memory writes the register file
- reg_write_adr_m  in  3  destination register in Memory
- reg_write_w  in  1  instruction in Writeback writes the register file
- reg_write_adr_w  in  3  destination register in Writeback
- PC_source  in  1  taken branch/jump resolved; redirect PC
- stats_clear  in  1  synchronous clear of all counters
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_d  out  1  clear F/D register
- flush_e  out  1  clear D/E register
- forward1_e  out  2  operand-1 select: 00 register file, 01 Writeback result, 10 Memory ALU result
- forward2_e  out  2  operand-2 select, same encoding
- stall_count, flush_count, fwd_count  out  STAT_W  event counters

## Operation
- All 8 registers take part in matching; register 0 has no exemption.
- forwardN_e (N=1,2): 10 if reg_write_m && reg_write_adr_m == reg_read_adrN_e; else 01 if reg_write_w && reg_write_adr_w == reg_read_adrN_e; else 00. Memory has priority over Writeback when both match. 11 is never produced.
- lw_stall = mem_to_reg_e && (reg_write_adr_e == reg_read_adr1_d || reg_write_adr_e == reg_read_adr2_d).
- stall_f = stall_d = lw_stall.
- flush_d = PC_source.
- flush_e = lw_stall || PC_source.
- Simultaneous lw_stall and PC_source: all four controls asserted; the flush of F/D takes effect over the stall.
- Hazard outputs are purely combinational, unaffected by clk and rst.

## Timing
- Zero-cycle latency on all hazard outputs; they settle within the same cycle their inputs change.
- Counters update on rising clk: stall_count +1 per cycle with lw_stall; flush_count +1 per cycle with PC_source; fwd_count +1 per cycle with either forward select nonzero.
- Counters saturate at 2^STAT_W-1 and do not wrap.
- stats_clear has priority over increment; the counter reads 0 on the next cycle.
- rst asserted: all counters 0 immediately (asynchronous) and held at 0 while rst is high; counting resumes on the first clk edge after release.
- Reset value of all outputs: the hazard outputs follow their inputs (all 0 when inputs are 0); counters are 0.

## Configuration
- HAZARD_STATS_EN defined: the statistics counters are built as described.
- HAZARD_STATS_EN undefined: no flops are built; the counter ports remain and are tied to 0; clk, rst and stats_clear are unused. Hazard outputs are identical in both builds.

## Test plan
- All inputs 0 -> all outputs 0, forward1_e = forward2_e = 00.
- reg_write_m=1, reg_write_adr_m=3, reg_read_adr1_e=3 -> forward1_e=10. Then reg_read_adr1_e=2, reg_write_w=1, reg_write_adr_w=2 -> forward1_e=01. Then reg_write_adr_m=2 -> forward1_e=10 (Memory priority).
- PC_source=1, no load -> flush_d=1, flush_e=1, stall_f=stall_d=0.
- reg_write_adr_e=5, reg_read_adr1_d=5, mem_to_reg_e=1 -> stall_f=stall_d=1, flush_e=1. The same with mem_to_reg_e=0 -> no stall.
- HAZARD_STATS_EN: hold lw_stall for 3 cycles -> stall_count=3. Pulse stats_clear -> 0. Assert rst mid-count -> 0 asynchronously. Force 2^16 stall cycles -> count saturates at 65535.
- Read-port 2 symmetry: reg_read_adr2_e=4, reg_write_w=1, reg_write_adr_w=4 -> forward2_e=01. Load-use via reg_read_adr2_d -> stall.
